// File: rtl/rv_mini_core_pkg.sv
// Shared types, opcode/funct constants and decoder for the mini RISC-V core.
// Latency: n/a (types and a pure combinational function).
// Backpressure: none; the core never stalls.
package rv_mini_core_pkg;

  localparam int DEF_XLEN    = 32;
  localparam int DEF_DWIDTH  = 8;
  localparam int DEF_AWIDTH  = 5;
  localparam int DEF_IMEM_AW = 8;

  typedef enum logic [2:0] {
    ALU_AND = 3'b000,
    ALU_OR  = 3'b001,
    ALU_ADD = 3'b010,
    ALU_XOR = 3'b011,
    ALU_SUB = 3'b110,
    ALU_SLT = 3'b111
  } aluop_sel_t;

  localparam logic [6:0] OP_R = 7'b0110011;
  localparam logic [6:0] OP_I = 7'b0010011;

  localparam logic [2:0] F3_ADD = 3'b000;
  localparam logic [2:0] F3_SLT = 3'b010;
  localparam logic [2:0] F3_XOR = 3'b100;
  localparam logic [2:0] F3_OR  = 3'b110;
  localparam logic [2:0] F3_AND = 3'b111;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_SUB  = 7'b0100000;

  typedef struct packed {
    logic [6:0] funct7;
    logic [4:0] rs2;
    logic [4:0] rs1;
    logic [2:0] funct3;
    logic [4:0] rd;
    logic [6:0] opcode;
  } r_instr_t;

  typedef struct packed {
    logic [11:0] imm;
    logic [4:0]  rs1;
    logic [2:0]  funct3;
    logic [4:0]  rd;
    logic [6:0]  opcode;
  } i_instr_t;

  typedef union packed {
    r_instr_t r;
    i_instr_t i;
  } instr_t;

  typedef struct packed {
    logic       wen;
    logic       alu_src_imm;
    aluop_sel_t alu_sel;
  } ctrl_t;

  // Decoder: anything not explicitly recognised suppresses writeback, so
  // unknown words behave as no-ops on architectural state.
  function automatic ctrl_t ctrl_unit(input instr_t ins);
    ctrl_t c;
    c.wen         = 1'b0;
    c.alu_src_imm = 1'b0;
    c.alu_sel     = ALU_ADD;
    case (ins.r.opcode)
      OP_R: begin
        c.wen = 1'b1;
        if (ins.r.funct7 == F7_SUB && ins.r.funct3 == F3_ADD) begin
          c.alu_sel = ALU_SUB;
        end else if (ins.r.funct7 == F7_BASE) begin
          case (ins.r.funct3)
            F3_ADD:  c.alu_sel = ALU_ADD;
            F3_AND:  c.alu_sel = ALU_AND;
            F3_OR:   c.alu_sel = ALU_OR;
            F3_XOR:  c.alu_sel = ALU_XOR;
            F3_SLT:  c.alu_sel = ALU_SLT;
            default: c.wen     = 1'b0;
          endcase
        end else begin
          c.wen = 1'b0;
        end
      end
      OP_I: begin
        c.wen         = 1'b1;
        c.alu_src_imm = 1'b1;
        case (ins.i.funct3)
          F3_ADD:  c.alu_sel = ALU_ADD;
          F3_AND:  c.alu_sel = ALU_AND;
          F3_OR:   c.alu_sel = ALU_OR;
          F3_XOR:  c.alu_sel = ALU_XOR;
          F3_SLT:  c.alu_sel = ALU_SLT;
          default: c.wen     = 1'b0;
        endcase
      end
      default: ;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/rv_mini_core_if.sv
// Load/observe bus of the mini core: imem loader in, architectural state out.
// Latency: pure wiring.
// Backpressure: none; loads are accepted every cycle imem_we is high.
interface rv_mini_core_if
  import rv_mini_core_pkg::*;
#(
  parameter int XLEN    = DEF_XLEN,
  parameter int DWIDTH  = DEF_DWIDTH,
  parameter int IMEM_AW = DEF_IMEM_AW
);
  logic               imem_we;
  logic [IMEM_AW-1:0] imem_waddr;
  logic [XLEN-1:0]    imem_wdata;
  logic [IMEM_AW-1:0] pc;
  logic [XLEN-1:0]    instr;
  logic [DWIDTH-1:0]  alu_res;
  logic               res_is_0;

  modport master (
    output imem_we, imem_waddr, imem_wdata,
    input  pc, instr, alu_res, res_is_0
  );

  modport slave (
    input  imem_we, imem_waddr, imem_wdata,
    output pc, instr, alu_res, res_is_0
  );
endinterface

// File: rtl/rv_alu.sv
// Combinational DWIDTH-bit ALU: AND/OR/XOR/ADD/SUB/unsigned SLT, results mod 2**DWIDTH.
// Latency: 0 cycles.
// Backpressure: none.
module rv_alu
  import rv_mini_core_pkg::*;
#(
  parameter int DWIDTH = DEF_DWIDTH
) (
  input  logic [DWIDTH-1:0] a_i,
  input  logic [DWIDTH-1:0] b_i,
  input  aluop_sel_t        sel_i,
  output logic [DWIDTH-1:0] res_o,
  output logic              zero_o
);

  // Operation select; carries/borrows fall off the top of the result.
  always_comb begin
    res_o = '0;
    case (sel_i)
      ALU_AND: res_o = a_i & b_i;
      ALU_OR:  res_o = a_i | b_i;
      ALU_XOR: res_o = a_i ^ b_i;
      ALU_ADD: res_o = a_i + b_i;
      ALU_SUB: res_o = a_i - b_i;
      ALU_SLT: res_o = {{(DWIDTH-1){1'b0}}, (a_i < b_i)};
      default: res_o = '0;
    endcase
  end

  assign zero_o = ~|res_o;

endmodule

// File: rtl/rv_mini_core.sv
// Single-cycle reduced RV datapath: PC, async imem, decoder, 32-entry regfile, ALU.
// Latency: result combinational in the instruction's cycle, committed at the next edge.
// Backpressure: none; one instruction retires per clock, no stalls.
module rv_mini_core
  import rv_mini_core_pkg::*;
#(
  parameter int XLEN    = DEF_XLEN,
  parameter int DWIDTH  = DEF_DWIDTH,
  parameter int AWIDTH  = DEF_AWIDTH,
  parameter int IMEM_AW = DEF_IMEM_AW
) (
  input logic          clk,
  input logic          rst,
  rv_mini_core_if.slave bus
);

  localparam int NREGS  = 2**AWIDTH;
  localparam int NWORDS = 2**IMEM_AW;

  logic [IMEM_AW-1:0] pc_q;
  logic [IMEM_AW-1:0] pc_d;
  logic [XLEN-1:0]    imem_q [NWORDS];
  logic [DWIDTH-1:0]  rf_q [NREGS];

  instr_t             ins;
  ctrl_t              ctrl;
  logic [DWIDTH-1:0]  rs1_val;
  logic [DWIDTH-1:0]  rs2_val;
  logic [DWIDTH-1:0]  imm_val;
  logic [DWIDTH-1:0]  op_b;
  logic [DWIDTH-1:0]  alu_res;
  logic               alu_zero;
  logic               rf_we;

  // Fetch is a plain array read, so a same-cycle load to pc's slot is only
  // seen after the edge that writes it.
  assign ins  = instr_t'(imem_q[pc_q]);
  assign ctrl = ctrl_unit(ins);

  // x0 is hardwired; the reads mask it even though rf_q[0] is never written.
  assign rs1_val = (ins.r.rs1 == '0) ? '0 : rf_q[ins.r.rs1];
  assign rs2_val = (ins.r.rs2 == '0) ? '0 : rf_q[ins.r.rs2];
  assign imm_val = ins.i.imm[DWIDTH-1:0];
  assign op_b    = ctrl.alu_src_imm ? imm_val : rs2_val;

  rv_alu #(
    .DWIDTH (DWIDTH)
  ) u_alu (
    .a_i    (rs1_val),
    .b_i    (op_b),
    .sel_i  (ctrl.alu_sel),
    .res_o  (alu_res),
    .zero_o (alu_zero)
  );

  assign rf_we = ctrl.wen && (ins.r.rd != '0);
  assign pc_d  = pc_q + 1'b1;

  // PC advances every cycle and wraps naturally at 2**IMEM_AW.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q <= '0;
    end else begin
      pc_q <= pc_d;
    end
  end

  // Register file write port; reset clears all and drops the in-flight result.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < NREGS; r++) begin
        rf_q[r] <= '0;
      end
    end else if (rf_we) begin
      rf_q[ins.r.rd] <= alu_res;
    end
  end

  // Instruction loader; deliberately independent of rst so programs can be
  // loaded while the core is held in reset.
  always_ff @(posedge clk) begin
    if (bus.imem_we) begin
      imem_q[bus.imem_waddr] <= bus.imem_wdata;
    end
  end

  assign bus.pc       = pc_q;
  assign bus.instr    = ins;
  assign bus.alu_res  = alu_res;
  assign bus.res_is_0 = alu_zero;

endmodule

// File: tb/tb_rv_mini_core.sv
// Directed bench for rv_mini_core: hand-encoded programs with hand-computed results.
// Latency: checks sample combinational outputs 1 time unit after each falling edge.
// Backpressure: none; the core retires one instruction per clock.
module tb_rv_mini_core;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  logic [31:0] prog_q [$];
  logic [7:0]  exp_q  [$];
  bit          chk_q  [$];

  rv_mini_core_if bus ();

  rv_mini_core dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h expected=%0h", tag, act, exp);
    end
  endtask

  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3,
                                        input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'b0110011};
  endfunction

  function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd);
    return {imm, rs1, f3, rd, 7'b0010011};
  endfunction

  // "or x0, a, b": reads two registers onto alu_res without writing anything.
  function automatic logic [31:0] probe(input logic [4:0] a, input logic [4:0] b);
    return enc_r(7'h00, b, a, 3'b110, 5'd0);
  endfunction

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic mem_write(input logic [7:0] a, input logic [31:0] w);
    bus.imem_we    = 1'b1;
    bus.imem_waddr = a;
    bus.imem_wdata = w;
    tick();
    bus.imem_we    = 1'b0;
  endtask

  task automatic put(input logic [31:0] w, input logic [7:0] e, input bit c);
    prog_q.push_back(w);
    exp_q.push_back(e);
    chk_q.push_back(c);
  endtask

  task automatic run_prog(input string name);
    rst = 1'b1;
    for (int i = 0; i < prog_q.size(); i++) mem_write(8'(i), prog_q[i]);
    rst = 1'b0;
    for (int i = 0; i < prog_q.size(); i++) begin
      #1;
      check_eq($sformatf("%s[%0d].pc", name, i), {24'h0, bus.pc}, 32'(i));
      check_eq($sformatf("%s[%0d].instr", name, i), bus.instr, prog_q[i]);
      if (chk_q[i]) begin
        check_eq($sformatf("%s[%0d].res", name, i), {24'h0, bus.alu_res}, {24'h0, exp_q[i]});
        check_eq($sformatf("%s[%0d].zero", name, i), {31'h0, bus.res_is_0},
                 {31'h0, (exp_q[i] == 8'h00)});
      end
      tick();
    end
    prog_q.delete();
    exp_q.delete();
    chk_q.delete();
  endtask

  initial begin
    n_checks       = 0;
    n_fail         = 0;
    rst            = 1'b1;
    bus.imem_we    = 1'b0;
    bus.imem_waddr = '0;
    bus.imem_wdata = '0;
    @(negedge clk);

    // ---- Reset: x5 written, reset held two edges, all registers back to 0
    mem_write(8'd0, enc_i(12'h02A, 5'd0, 3'b000, 5'd5));
    mem_write(8'd1, probe(5'd5, 5'd0));
    mem_write(8'd2, enc_i(12'h033, 5'd0, 3'b000, 5'd5));
    for (int k = 0; k < 16; k++) mem_write(8'(3 + k), probe(5'(2 * k), 5'(2 * k + 1)));
    #1 check_eq("rst_pc0", {24'h0, bus.pc}, 32'h0);
    rst = 1'b0;
    #1 check_eq("rst_addi_x5", {24'h0, bus.alu_res}, 32'h2A);
    tick();
    #1 check_eq("rst_x5_written", {24'h0, bus.alu_res}, 32'h2A);
    tick();
    #1 check_eq("rst_pc2", {24'h0, bus.pc}, 32'h2);
    rst = 1'b1;
    mem_write(8'd0, probe(5'd5, 5'd0));
    mem_write(8'd1, probe(5'd0, 5'd5));
    rst = 1'b0;
    #1 check_eq("rst_pc_after", {24'h0, bus.pc}, 32'h0);
    check_eq("rst_x5_clear", {24'h0, bus.alu_res}, 32'h0);
    mem_write(8'd2, probe(5'd5, 5'd5));
    #1 check_eq("rst_x5_clear_b", {24'h0, bus.alu_res}, 32'h0);
    tick();
    #1 check_eq("rst_inflight_dropped", {24'h0, bus.alu_res}, 32'h0);
    tick();
    for (int k = 0; k < 16; k++) begin
      #1 check_eq($sformatf("rst_pair%0d", k), {24'h0, bus.alu_res}, 32'h0);
      tick();
    end

    // ---- I-type chain and dependent R-type
    put(enc_i(12'h005, 5'd0, 3'b000, 5'd1), 8'h05, 1'b1);
    put(enc_i(12'h003, 5'd0, 3'b000, 5'd2), 8'h03, 1'b1);
    put(enc_r(7'h00, 5'd2, 5'd1, 3'b000, 5'd3), 8'h08, 1'b1);
    put(enc_r(7'h20, 5'd2, 5'd1, 3'b000, 5'd4), 8'h02, 1'b1);
    put(probe(5'd3, 5'd0), 8'h08, 1'b1);
    put(probe(5'd4, 5'd0), 8'h02, 1'b1);
    run_prog("chain");

    // ---- Logic and compare, R and I forms, immediate truncation
    put(enc_i(12'h00F, 5'd0, 3'b000, 5'd1), 8'h0F, 1'b1);
    put(enc_i(12'h03C, 5'd0, 3'b000, 5'd2), 8'h3C, 1'b1);
    put(enc_r(7'h00, 5'd2, 5'd1, 3'b111, 5'd3), 8'h0C, 1'b1);
    put(enc_r(7'h00, 5'd2, 5'd1, 3'b110, 5'd4), 8'h3F, 1'b1);
    put(enc_r(7'h00, 5'd2, 5'd1, 3'b100, 5'd5), 8'h33, 1'b1);
    put(enc_r(7'h00, 5'd1, 5'd2, 3'b010, 5'd5), 8'h00, 1'b1);
    put(enc_r(7'h00, 5'd2, 5'd1, 3'b010, 5'd6), 8'h01, 1'b1);
    put(enc_i(12'h010, 5'd1, 3'b010, 5'd7), 8'h01, 1'b1);
    put(probe(5'd5, 5'd0), 8'h00, 1'b1);
    put(probe(5'd6, 5'd7), 8'h01, 1'b1);
    put(enc_i(12'h03C, 5'd1, 3'b111, 5'd8), 8'h0C, 1'b1);
    put(enc_i(12'h030, 5'd1, 3'b110, 5'd9), 8'h3F, 1'b1);
    put(enc_i(12'h0FF, 5'd1, 3'b100, 5'd10), 8'hF0, 1'b1);
    put(enc_i(12'h105, 5'd1, 3'b010, 5'd11), 8'h00, 1'b1);
    put(enc_i(12'h1F0, 5'd0, 3'b000, 5'd12), 8'hF0, 1'b1);
    put(probe(5'd12, 5'd0), 8'hF0, 1'b1);
    run_prog("logic");

    // ---- Wrap-around arithmetic and zero flag
    put(enc_i(12'h0FF, 5'd0, 3'b000, 5'd1), 8'hFF, 1'b1);
    put(enc_i(12'h001, 5'd1, 3'b000, 5'd2), 8'h00, 1'b1);
    put(enc_r(7'h20, 5'd1, 5'd1, 3'b000, 5'd3), 8'h00, 1'b1);
    put(probe(5'd2, 5'd0), 8'h00, 1'b1);
    put(enc_r(7'h00, 5'd1, 5'd1, 3'b000, 5'd4), 8'hFE, 1'b1);
    put(enc_r(7'h20, 5'd1, 5'd0, 3'b000, 5'd5), 8'h01, 1'b1);
    run_prog("wrap");

    // ---- x0 writes and illegal/unsupported words leave state untouched
    put(enc_i(12'h011, 5'd0, 3'b000, 5'd1), 8'h11, 1'b1);
    put(enc_i(12'h022, 5'd0, 3'b000, 5'd2), 8'h22, 1'b1);
    put(enc_i(12'h007, 5'd0, 3'b000, 5'd0), 8'h07, 1'b1);
    put(enc_r(7'h00, 5'd1, 5'd0, 3'b000, 5'd0), 8'h11, 1'b1);
    put(32'h0000_0000, 8'h00, 1'b1);
    put(enc_r(7'h20, 5'd2, 5'd1, 3'b111, 5'd1), 8'h00, 1'b0);
    put(enc_r(7'h00, 5'd0, 5'd1, 3'b000, 5'd0), 8'h11, 1'b1);
    put(enc_i(12'h005, 5'd1, 3'b001, 5'd1), 8'h00, 1'b0);
    put(32'h0000_50B7, 8'h00, 1'b0);
    put(enc_r(7'h00, 5'd0, 5'd1, 3'b000, 5'd0), 8'h11, 1'b1);
    run_prog("x0_illegal");

    // ---- PC wraps 255 -> 0 -> 1
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    for (int i = 0; i < 258; i++) begin
      #1 check_eq($sformatf("pc_wrap%0d", i), {24'h0, bus.pc}, 32'(i % 256));
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/rv_mini_core.md
Name: rv_mini_core

Overview:
- Single-cycle, reduced RISC-V integer datapath.
- Contains:
  - 8-bit PC register
  - combinational instruction memory (mem_comb function)
  - decoder (ctrl_unit function)
  - 32-entry register file
  - immediate/register operand mux
  - ALU (alu function)
- Executes one R-type or I-type ALU instruction per clock on DWIDTH-bit data.
- Used as the execution core under the processor-level bench.

Parameters:
- XLEN, 32, instruction word width.
- DWIDTH, 8, register/ALU data width.
- AWIDTH, 5, register-file address width (2**AWIDTH registers).
- IMEM_AW, 8, instruction-memory address width (256 words); also the PC width.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- imem_we  input  1  instruction-memory load strobe.
- imem_waddr  input  IMEM_AW  load address.
- imem_wdata  input  XLEN  load data.
- pc  output  IMEM_AW  current PC.
- instr  output  XLEN  instruction at current PC (combinational).
- alu_res  output  DWIDTH  ALU result; also the writeback data.
- res_is_0  output  1  high when alu_res == 0.

Behaviour:
- **Reset**
  - Reset: one clock, synchronous, active-high (rst).
  - On a clk edge with rst=1:
    - PC <= 0.
    - All registers <= 0.
    - No writeback occurs.
  - Instruction memory is not cleared.
  - Reset asserted mid-program takes effect at the next edge; the in-flight instruction is discarded.
- **PC**
  - PC <= PC+1 every non-reset edge.
  - Wraps 255 -> 0 (modulo 2**IMEM_AW).
  - No branches.
- **Instruction memory**
  - Asynchronous read: instr = mem[pc].
  - Synchronous write on clk when imem_we=1; allowed while rst=1.
  - Read of the address being written returns the old word until the edge.
- **Instruction fields**
  - opcode[6:0], rd[11:7], funct3[14:12], rs1[19:15], rs2[24:20], funct7[31:25], imm[31:20].
- **Decode**
  - R-type opcode 0110011: wen=1, alu_src=register.
    - funct3/funct7 000/0000000 -> ADD
    - 000/0100000 -> SUB
    - 111 -> AND
    - 110 -> OR
    - 100 -> XOR
    - 010 -> SLT
    - Any other funct combination: wen=0.
  - I-type opcode 0010011: wen=1, alu_src=immediate.
    - funct3 000 -> ADD
    - 111 -> AND
    - 110 -> OR
    - 100 -> XOR
    - 010 -> SLT
    - Other funct3 values: wen=0.
  - Any other opcode: wen=0, alu_sel=ADD.
- **Immediate**
  - imm[DWIDTH-1:0], i.e. the low DWIDTH bits of the 12-bit immediate (truncation).
- **Register file**
  - Two async read ports (rs1, rs2) and one sync write port (rd, alu_res, wen).
  - x0 reads 0; writes to x0 are ignored.
  - Read-during-write returns the old value; the new value is visible the next cycle.
- **ALU** (combinational, DWIDTH-bit, all results mod 2**DWIDTH)
  - AND, OR, XOR: bitwise.
  - ADD, SUB: carry/borrow dropped.
  - SLT: unsigned compare, result 1 or 0 zero-extended.
  - res_is_0 = ~|alu_res.
- **Timing**
  - Latency: result is combinational in the instruction's cycle and committed at the following rising edge.
  - Back-to-back dependent instructions are correct without stalls.

Decomposition:
- typedefs_pkg (shared) holds:
  - aluop_sel_t enum: AND=3'b000, OR=3'b001, ADD=3'b010, XOR=3'b011, SUB=3'b110, SLT=3'b111.
  - instr_t packed union with R and I struct views.
  - Opcode constants OP_R=7'b0110011 and OP_I=7'b0010011.
  - funct3/funct7 constants.
- One sub-module is natural: rv_alu (pure combinational ALU).
- Decode, register file and PC stay inline.

Test Plan:
- **Reset**: hold rst=1 for 2 edges after writing x5 -> pc=0 and every register reads 0.
- **I-type chain**: load addi x1,x0,5; addi x2,x0,3; add x3,x1,x2; sub x4,x1,x2 -> x3=08, x4=02.
- **Logic/compare**:
  - x1=0x0F, x2=0x3C: and=0x0C, or=0x3F, xor=0x33.
  - slt x5,x2,x1=0; slt x6,x1,x2=1.
  - slti x7,x1,0x10=1.
- **Wrap and zero flag**:
  - addi x1,x0,0xFF then addi x2,x1,1 -> alu_res=0x00, res_is_0=1, x2=0.
  - sub x3,x1,x1 -> res_is_0=1.
- **x0 and illegal**:
  - addi x0,x0,7 -> x0 still reads 0.
  - Word 0x00000000 -> no register changes.
  - R-type funct7=0x20 with funct3=111 -> wen=0.
- **PC wrap**: run 257 cycles from reset -> pc sequence ... 255, 0, 1.
